// File: rtl/sdram_dl_arb.sv
// Arbiter that merges a download (loader) write stream into the CPU's SDRAM port.
// Optional 16->32 bit packing of loader halves is enabled by defining SDRAM_DL_ARB_PACK_EN.
module sdram_dl_arb (
   input  logic        SDRAM_CLK,
   input  logic        RST,
   input  logic        CPU_CLKREF,
   input  logic [24:0] CPU_WADDR,
   input  logic [31:0] CPU_DIN,
   input  logic [3:0]  CPU_BE,
   input  logic        CPU_WE,
   output logic        CPU_WE_RDY,
   input  logic        CPU_RD,
   output logic        CPU_RD_RDY,
   input  logic [24:0] CPU_RADDR,
   output logic [31:0] CPU_DOUT,
   input  logic        DL_ACTIVE,
   input  logic        DL_WR,
   input  logic [24:0] DL_ADDR,
   input  logic [15:0] DL_DATA,
   output logic        DL_WAIT,
   output logic        DL_OVF,
   output logic [24:0] C_WADDR,
   output logic [31:0] C_DIN,
   output logic [3:0]  C_BE,
   output logic        C_WE,
   input  logic        C_WE_RDY,
   output logic        C_RD,
   input  logic        C_RD_RDY,
   output logic [24:0] C_RADDR,
   input  logic [31:0] C_DOUT
);
   typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

   state_t      state, state_next;
   logic [22:0] fifo_addr [4];
   logic [31:0] fifo_data [4];
   logic [3:0]  fifo_be   [4];
   logic [1:0]  wr_ptr, rd_ptr;
   logic [2:0]  count, count_next;
   logic        dl_wait_q, dl_ovf_q, dl_active_q, dl_rise;
   logic        push, push_ok, drop, pop;
   logic [22:0] push_addr;
   logic [31:0] push_data;
   logic [3:0]  push_be;
   logic        unused_bits;

   // DL_ADDR bit 0 is a byte select inside a 16-bit half and has no meaning here.
   assign unused_bits = DL_ADDR[0];
   assign dl_rise     = DL_ACTIVE & ~dl_active_q;

`ifdef SDRAM_DL_ARB_PACK_EN
   logic        pk_valid, pk_hi, pk_valid_next, pk_hi_next, dl_fall, pair_hit;
   logic [22:0] pk_addr, pk_addr_next;
   logic [15:0] pk_data, pk_data_next;

   assign dl_fall  = ~DL_ACTIVE & dl_active_q;
   assign pair_hit = pk_valid & ~pk_hi & DL_ADDR[1] & (DL_ADDR[24:2] == pk_addr);

   // A held half leaves alone unless the very next strobe is its upper partner.
   always_comb begin
      push          = 1'b0;
      push_addr     = pk_addr;
      push_data     = {pk_data, pk_data};
      push_be       = pk_hi ? 4'b1100 : 4'b0011;
      pk_valid_next = pk_valid;
      pk_hi_next    = pk_hi;
      pk_addr_next  = pk_addr;
      pk_data_next  = pk_data;
      if (DL_WR) begin
         if (pair_hit) begin
            push          = 1'b1;
            push_data     = {DL_DATA, pk_data};
            push_be       = 4'b1111;
            pk_valid_next = 1'b0;
         end else begin
            push          = pk_valid;
            pk_valid_next = 1'b1;
            pk_hi_next    = DL_ADDR[1];
            pk_addr_next  = DL_ADDR[24:2];
            pk_data_next  = DL_DATA;
         end
      end else if (dl_fall && pk_valid) begin
         push          = 1'b1;
         pk_valid_next = 1'b0;
      end
   end

   always_ff @(posedge SDRAM_CLK or posedge RST) begin
      if (RST) begin
         pk_valid <= 1'b0;
         pk_hi    <= 1'b0;
         pk_addr  <= '0;
         pk_data  <= '0;
      end else begin
         pk_valid <= pk_valid_next;
         pk_hi    <= pk_hi_next;
         pk_addr  <= pk_addr_next;
         pk_data  <= pk_data_next;
      end
   end
`else
   assign push      = DL_WR;
   assign push_addr = DL_ADDR[24:2];
   assign push_data = {DL_DATA, DL_DATA};
   assign push_be   = DL_ADDR[1] ? 4'b1100 : 4'b0011;
`endif

   assign drop       = push & (count == 3'd4);
   assign push_ok    = push & ~drop;
   assign pop        = (state == ISSUE);
   assign count_next = count + {2'b00, push_ok} - {2'b00, pop};

   always_ff @(posedge SDRAM_CLK) begin
      if (push_ok) begin
         fifo_addr[wr_ptr] <= push_addr;
         fifo_data[wr_ptr] <= push_data;
         fifo_be[wr_ptr]   <= push_be;
      end
   end

   always_ff @(posedge SDRAM_CLK or posedge RST) begin
      if (RST) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         dl_wait_q   <= 1'b0;
         dl_ovf_q    <= 1'b0;
         dl_active_q <= 1'b0;
      end else begin
         state       <= state_next;
         wr_ptr      <= wr_ptr + {1'b0, push_ok};
         rd_ptr      <= rd_ptr + {1'b0, pop};
         count       <= count_next;
         dl_wait_q   <= (count_next >= 3'd3);
         dl_active_q <= DL_ACTIVE;
         if (drop)
            dl_ovf_q <= 1'b1;
         else if (dl_rise)
            dl_ovf_q <= 1'b0;
      end
   end

   // Loader only grabs the port when the CPU is demonstrably idle; RDY gating uses state only.
   always_comb begin
      state_next = state;
      C_WE       = CPU_WE;
      C_RD       = CPU_RD;
      C_WADDR    = CPU_WADDR;
      C_DIN      = CPU_DIN;
      C_BE       = CPU_BE;
      C_RADDR    = CPU_RADDR;
      CPU_WE_RDY = C_WE_RDY;
      CPU_RD_RDY = C_RD_RDY;
      case (state)
         IDLE: begin
            if ((count != 3'd0) && C_WE_RDY && C_RD_RDY && !CPU_CLKREF && !CPU_WE && !CPU_RD)
               state_next = ISSUE;
         end
         ISSUE: begin
            state_next = BUSY;
            C_WE       = 1'b1;
            C_RD       = 1'b0;
            C_WADDR    = {fifo_addr[rd_ptr], 2'b00};
            C_DIN      = fifo_data[rd_ptr];
            C_BE       = fifo_be[rd_ptr];
            CPU_WE_RDY = 1'b0;
            CPU_RD_RDY = 1'b0;
         end
         BUSY: begin
            if (C_WE_RDY)
               state_next = IDLE;
            C_WE       = 1'b0;
            C_RD       = 1'b0;
            CPU_WE_RDY = 1'b0;
            CPU_RD_RDY = 1'b0;
         end
         default: state_next = IDLE;
      endcase
   end

   assign CPU_DOUT = C_DOUT;
   assign DL_WAIT  = dl_wait_q;
   assign DL_OVF   = dl_ovf_q;
endmodule

// File: doc/sdram_dl_arb.md
SDRAM_DL_ARB -- requirements
Module: sdram_dl_arb

Interface
REQ-001 SHALL have: SDRAM_CLK  in  1  sole clock; all state on rising edge.
REQ-002 SHALL have: RST  in  1  asynchronous, active-high reset.
REQ-003 SHALL have CPU-side port (from memory interface): CPU_CLKREF in 1, CPU_WADDR in 25, CPU_DIN in 32, CPU_BE in 4, CPU_WE in 1, CPU_WE_RDY out 1, CPU_RD in 1, CPU_RD_RDY out 1, CPU_RADDR in 25, CPU_DOUT out 32.
REQ-004 SHALL have download port: DL_ACTIVE in 1 (load session), DL_WR in 1 (one-cycle strobe), DL_ADDR in 25 (byte address, bit0 ignored), DL_DATA in 16, DL_WAIT out 1 (backpressure), DL_OVF out 1 (sticky drop flag).
REQ-005 SHALL have controller port: C_WADDR out 25, C_DIN out 32, C_BE out 4, C_WE out 1, C_WE_RDY in 1, C_RD out 1, C_RD_RDY in 1, C_RADDR out 25, C_DOUT in 32.

Function
REQ-006 SHALL buffer download writes in a 4-entry FIFO of {word address DL_ADDR[24:2], data 32, BE 4}.
REQ-007 SHALL drive DL_WAIT high when FIFO count >= 3 (registered).
REQ-008 DL_WR with FIFO full SHALL drop the entry and set DL_OVF; DL_OVF clears only on RST or DL_ACTIVE rising edge.
REQ-009 SHALL run arbiter FSM IDLE -> ISSUE -> BUSY -> IDLE.
REQ-010 IDLE->ISSUE when FIFO non-empty, C_WE_RDY=1, C_RD_RDY=1, CPU_CLKREF=0, CPU_WE=0, CPU_RD=0, all in same cycle.
REQ-011 ISSUE (exactly 1 cycle): C_WE=1 with FIFO head addr/data/BE; head popped; -> BUSY.
REQ-012 BUSY: stay while C_WE_RDY=0; -> IDLE on first cycle C_WE_RDY=1.
REQ-013 In IDLE: C_WE=CPU_WE, C_RD=CPU_RD, C_WADDR/C_DIN/C_BE/C_RADDR from CPU port, CPU_WE_RDY=C_WE_RDY, CPU_RD_RDY=C_RD_RDY (combinational pass-through).
REQ-014 In ISSUE/BUSY: CPU_WE_RDY=0, CPU_RD_RDY=0, CPU_WE/CPU_RD ignored; RDY gating SHALL depend only on registered state (no comb loop through CPU_WE).
REQ-015 CPU_DOUT SHALL equal C_DOUT in all states.
REQ-016 CPU has priority: a loader write starts only per REQ-010; max one loader write per idle gap.
REQ-017 Simultaneous push and pop SHALL keep count unchanged; pointers wrap modulo 4.

Reset
REQ-018 On RST: state=IDLE, FIFO empty, pack register empty, DL_WAIT=0, DL_OVF=0, C_WE=0 from loader side; pass-through outputs follow REQ-013 immediately.
REQ-019 RST during ISSUE/BUSY SHALL abandon the write; no retry after release.

Configuration
REQ-020 Macro SDRAM_DL_ARB_PACK_EN SHALL select 16->32 packing.
REQ-021 With SDRAM_DL_ARB_PACK_EN: DL_ADDR[1]=0 data held in pack register; following DL_WR to same word with DL_ADDR[1]=1 pushes {hi,lo}, BE=1111.
REQ-022 With macro: a pending half SHALL be pushed alone (BE=0011, data duplicated both halves) when next DL_WR targets a different word or DL_ADDR[1]=0, or on DL_ACTIVE falling edge; lone upper half pushes BE=1100.
REQ-023 Without macro: every DL_WR pushes immediately, data duplicated both halves, BE=0011 if DL_ADDR[1]=0 else 1100; no pack register.

Verification
REQ-024 Reset mid-BUSY: RST at BUSY -> next cycle state IDLE, CPU_WE_RDY=C_WE_RDY, FIFO empty.
REQ-025 Pass-through: IDLE, CPU_RD=1, CPU_RADDR=0x0100040 -> C_RD=1, C_RADDR=0x0100040 same cycle; C_DOUT=0xDEADBEEF -> CPU_DOUT=0xDEADBEEF.
REQ-026 Packing (macro on): DL_WR 0x0000000/0x1234 then 0x0000002/0xABCD -> single C_WE, C_WADDR=0x0000000, C_DIN=0xABCD1234, C_BE=1111.
REQ-027 Flush: DL_WR 0x0000004/0x5555 then DL_ACTIVE falls -> C_DIN=0x55555555, C_BE=0011 (macro on); macro off -> same write immediately after DL_WR.
REQ-028 Priority: FIFO non-empty, CPU_CLKREF=1 held 5 cycles -> no C_WE from loader until first cycle CPU_CLKREF=0 and CPU idle; during loader BUSY, CPU_WE_RDY=0.
REQ-029 Overflow: C_WE_RDY held 0, 5 DL_WR strobes ignoring DL_WAIT -> DL_WAIT=1 after 3rd, 5th dropped, DL_OVF=1 until next DL_ACTIVE rise.
